// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp decode for the two-way intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_AR_TO_NS  = 3'd1,
    ST_NS_GREEN  = 3'd2,
    ST_NS_YELLOW = 3'd3,
    ST_AR_TO_EW  = 3'd4,
    ST_EW_GREEN  = 3'd5,
    ST_EW_YELLOW = 3'd6,
    ST_FLASH     = 3'd7
  } state_t;

  typedef struct packed {
    logic ns_r;
    logic ns_y;
    logic ns_g;
    logic ew_r;
    logic ew_y;
    logic ew_g;
  } lamps_t;

  function automatic logic is_all_red(input state_t st);
    return (st == ST_AR_TO_NS) || (st == ST_AR_TO_EW);
  endfunction

  function automatic lamps_t lamp_decode(input state_t st, input logic flash_lit);
    lamps_t l;
    l = '0;
    case (st)
      ST_AR_TO_NS, ST_AR_TO_EW: begin
        l.ns_r = 1'b1;
        l.ew_r = 1'b1;
      end
      ST_NS_GREEN: begin
        l.ns_g = 1'b1;
        l.ew_r = 1'b1;
      end
      ST_NS_YELLOW: begin
        l.ns_y = 1'b1;
        l.ew_r = 1'b1;
      end
      ST_EW_GREEN: begin
        l.ew_g = 1'b1;
        l.ns_r = 1'b1;
      end
      ST_EW_YELLOW: begin
        l.ew_y = 1'b1;
        l.ns_r = 1'b1;
      end
      ST_FLASH: begin
        l.ns_y = flash_lit;
        l.ew_y = flash_lit;
      end
      default: l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_ctrl_2way_phase_timer.sv
// Phase timer: counts up from zero each cycle, flags the last cycle of a phase.
module phase_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [TIMER_W-1:0] dur,
  output logic               done,
  output logic [TIMER_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

  assign done = (count == (dur - TIMER_W'(1)));

endmodule

// File: rtl/traffic_ctrl_2way.sv
// Two-direction intersection controller with all-red clearance, pedestrian
// WALK service in clearance phases, and flashing-yellow maintenance mode.
module traffic_ctrl_2way
  import traffic_pkg::*;
#(
  parameter int unsigned TIMER_W      = 8,
  parameter int unsigned GREEN_T      = 8,
  parameter int unsigned YELLOW_T     = 3,
  parameter int unsigned CLR_T        = 2,
  parameter int unsigned PED_T        = 6,
  parameter int unsigned FLASH_HALF_T = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       on,
  input  logic       flash,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] state_out
);

  localparam longint unsigned DUR_MAX = (64'd1 << TIMER_W) - 64'd1;

  generate
    if (TIMER_W == 0 || TIMER_W > 32 ||
        GREEN_T == 0 || GREEN_T > DUR_MAX ||
        YELLOW_T == 0 || YELLOW_T > DUR_MAX ||
        CLR_T == 0 || CLR_T > DUR_MAX ||
        PED_T == 0 || PED_T > DUR_MAX ||
        FLASH_HALF_T == 0 || FLASH_HALF_T > DUR_MAX) begin : g_bad_cfg
      $error("traffic_ctrl_2way: phase duration out of range for TIMER_W");
    end
  endgenerate

  state_t             state, state_nx;
  logic               ped_pend_nx;
  logic               walk_active, walk_active_nx;
  logic               flash_lit, flash_lit_nx;
  logic               timer_clear, timer_done;
  logic [TIMER_W-1:0] timer_count;
  logic [TIMER_W-1:0] dur;
  logic               enter_ar;
  lamps_t             lamps;

  phase_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .dur     (dur),
    .done    (timer_done),
    .count   (timer_count)
  );

  always_comb begin
    dur = TIMER_W'(CLR_T);
    case (state)
      ST_AR_TO_NS, ST_AR_TO_EW:   dur = walk_active ? TIMER_W'(PED_T) : TIMER_W'(CLR_T);
      ST_NS_GREEN, ST_EW_GREEN:   dur = TIMER_W'(GREEN_T);
      ST_NS_YELLOW, ST_EW_YELLOW: dur = TIMER_W'(YELLOW_T);
      ST_FLASH:                   dur = TIMER_W'(FLASH_HALF_T);
      default:                    dur = TIMER_W'(CLR_T);
    endcase
  end

  always_comb begin
    state_nx = state;
    if (!on) begin
      state_nx = ST_OFF;
    end else if (flash) begin
      state_nx = ST_FLASH;
    end else begin
      case (state)
        ST_OFF, ST_FLASH: state_nx = ST_AR_TO_NS;
        ST_AR_TO_NS:      if (timer_done) state_nx = ST_NS_GREEN;
        ST_NS_GREEN:      if (timer_done) state_nx = ST_NS_YELLOW;
        ST_NS_YELLOW:     if (timer_done) state_nx = ST_AR_TO_EW;
        ST_AR_TO_EW:      if (timer_done) state_nx = ST_EW_GREEN;
        ST_EW_GREEN:      if (timer_done) state_nx = ST_EW_YELLOW;
        ST_EW_YELLOW:     if (timer_done) state_nx = ST_AR_TO_NS;
        default:          state_nx = ST_OFF;
      endcase
    end
  end

  // A request arriving on the AR-entry edge is kept for the next clearance.
  always_comb begin
    ped_pend_nx    = ped_pend;
    walk_active_nx = walk_active;
    flash_lit_nx   = flash_lit;
    enter_ar       = is_all_red(state_nx) && (state_nx != state);
    if (!on) begin
      ped_pend_nx    = 1'b0;
      walk_active_nx = 1'b0;
    end else if (!flash) begin
      if (enter_ar) begin
        walk_active_nx = ped_pend;
        ped_pend_nx    = ped_req;
      end else begin
        ped_pend_nx = ped_pend | ped_req;
      end
    end
    if (state_nx != ST_FLASH) begin
      flash_lit_nx = 1'b1;
    end else if (state == ST_FLASH && timer_done) begin
      flash_lit_nx = ~flash_lit;
    end
    timer_clear = !on || (state_nx != state) || (state == ST_FLASH && timer_done);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_OFF;
      ped_pend    <= 1'b0;
      walk_active <= 1'b0;
      flash_lit   <= 1'b1;
    end else begin
      state       <= state_nx;
      ped_pend    <= ped_pend_nx;
      walk_active <= walk_active_nx;
      flash_lit   <= flash_lit_nx;
    end
  end

  assign lamps     = lamp_decode(state, flash_lit);
  assign ns_red    = lamps.ns_r;
  assign ns_yellow = lamps.ns_y;
  assign ns_green  = lamps.ns_g;
  assign ew_red    = lamps.ew_r;
  assign ew_yellow = lamps.ew_y;
  assign ew_green  = lamps.ew_g;
  assign walk      = walk_active && is_all_red(state);
  assign state_out = state;

  a_timer_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    timer_count < dur);

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Randomised scoreboard bench for traffic_ctrl_2way against a phase/countdown model.
module tb_traffic_ctrl_2way;

  localparam int TW = 8;
  localparam int GT = 8;
  localparam int YT = 3;
  localparam int CT = 2;
  localparam int PT = 6;
  localparam int FH = 4;

  logic clk = 1'b0;
  logic reset_n, on, flash, ped_req;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pend;
  logic [2:0] state_out;
  logic [10:0] dut_vec;

  always #5 clk = ~clk;

  traffic_ctrl_2way #(
    .TIMER_W(TW), .GREEN_T(GT), .YELLOW_T(YT), .CLR_T(CT), .PED_T(PT), .FLASH_HALF_T(FH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .on(on), .flash(flash), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_pend(ped_pend), .state_out(state_out)
  );

  assign dut_vec = {state_out, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                    walk, ped_pend};

  int tests = 0;
  int fails = 0;
  logic [10:0] exp_q[$];

  // Model: phase number, cycles remaining in the phase, walk/pending flags, flash phase.
  int m_st, m_rem;
  bit m_walk, m_pend, m_lit;

  function automatic int phase_len(input int st, input bit w);
    if (st == 1 || st == 4) return w ? PT : CT;
    if (st == 2 || st == 5) return GT;
    return YT;
  endfunction

  function automatic logic [10:0] expect_vec();
    bit ar, nr, ny, ng, er, ey, eg;
    ar = (m_st == 1) || (m_st == 4);
    nr = ar || m_st == 5 || m_st == 6;
    er = ar || m_st == 2 || m_st == 3;
    ny = (m_st == 3) || (m_st == 7 && m_lit);
    ey = (m_st == 6) || (m_st == 7 && m_lit);
    ng = (m_st == 2);
    eg = (m_st == 5);
    return {3'(m_st), nr, ny, ng, er, ey, eg, ar && m_walk, m_pend};
  endfunction

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_walk = 0; m_pend = 0; m_lit = 1;
  endtask

  task automatic model_edge();
    bit entering;
    entering = 0;
    if (!reset_n) begin
      model_reset();
    end else if (!on) begin
      model_reset();
    end else if (flash) begin
      if (m_st != 7) begin
        m_st = 7; m_rem = FH; m_lit = 1;
      end else begin
        m_rem--;
        if (m_rem == 0) begin m_lit = !m_lit; m_rem = FH; end
      end
    end else begin
      if (m_st == 0 || m_st == 7) begin
        m_st = 1; entering = 1;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_st = (m_st == 6) ? 1 : m_st + 1;
          entering = 1;
        end
      end
      m_lit = 1;
      if (entering && (m_st == 1 || m_st == 4)) begin
        m_walk = m_pend;
        m_pend = ped_req;
      end else begin
        m_pend = m_pend | ped_req;
      end
      if (entering) m_rem = phase_len(m_st, m_walk);
    end
    exp_q.push_back(expect_vec());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic cycle(input bit o, input bit f, input bit p);
    @(negedge clk);
    on = o; flash = f; ped_req = p;
    tick();
  endtask

  task automatic wait_state(input int st, input string name);
    int n;
    n = 0;
    while (m_st != st && n < 60) begin
      cycle(1, 0, 0);
      n++;
    end
    if (m_st != st) begin
      tests++; fails++;
      $display("FAIL wait_%s: model state %0d, required %0d within 60 cycles", name, m_st, st);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the queue head.
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (dut_vec !== e) begin
          fails++;
          $display("FAIL outputs t=%0t: got st=%0d lamps=%b walk=%b pend=%b, required st=%0d lamps=%b walk=%b pend=%b",
                   $time, dut_vec[10:8], dut_vec[7:2], dut_vec[1], dut_vec[0],
                   e[10:8], e[7:2], e[1], e[0]);
        end
        if (state_out >= 3'd1 && state_out <= 3'd6) begin
          tests++;
          if (!ns_red && !ew_red) begin
            fails++;
            $display("FAIL red_interlock t=%0t: st=%0d ns_red=%b ew_red=%b, required at least one red",
                     $time, state_out, ns_red, ew_red);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r_on, r_fl, rp;
    int n;
    reset_n = 1'b0; on = 1'b0; flash = 1'b0; ped_req = 1'b0;
    model_reset();
    repeat (3) tick();
    @(negedge clk);
    reset_n = 1'b1;

    // Normal loop, no pedestrians: two full 26-cycle loops.
    repeat (60) cycle(1, 0, 0);

    // Pedestrian pulse in NS green serves an extended AR_TO_EW.
    wait_state(2, "ns_green_ped");
    cycle(1, 0, 1);
    repeat (40) cycle(1, 0, 0);

    // Flash during EW green, pedestrian requests ignored, then resume.
    wait_state(5, "ew_green_flash");
    repeat (20) cycle(1, 1, 1'($urandom_range(0, 1)));
    repeat (12) cycle(1, 0, 0);

    // Drop on in the third NS green cycle.
    wait_state(2, "ns_green_off");
    cycle(1, 0, 1);
    cycle(1, 0, 0);
    repeat (4) cycle(0, 0, 1'($urandom_range(0, 1)));
    repeat (30) cycle(1, 0, 0);

    // Level request: pending set again on the AR-entry edge.
    repeat (40) cycle(1, 0, 1);
    repeat (30) cycle(1, 0, 0);

    // Random soak with held on/flash levels.
    r_on = 1; r_fl = 0;
    repeat (3000) begin
      if (r_on) r_on = ($urandom_range(0, 149) != 0);
      else      r_on = ($urandom_range(0, 4) == 0);
      if (r_fl) r_fl = ($urandom_range(0, 14) != 0);
      else      r_fl = ($urandom_range(0, 149) == 0);
      rp = ($urandom_range(0, 9) == 0);
      cycle(r_on, r_fl, rp);
    end

    // Async reset between edges while WALK is shown.
    n = 0;
    while (!((m_st == 1 || m_st == 4) && m_walk) && n < 200) begin
      cycle(1, 0, 1);
      n++;
    end
    tests++;
    if (!((m_st == 1 || m_st == 4) && m_walk)) begin
      fails++;
      $display("FAIL wait_walk: no walk clearance reached within 200 cycles");
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (dut_vec !== 11'd0) begin
      fails++;
      $display("FAIL async_reset: got outputs %b, required all zero", dut_vec);
    end
    tick();
    @(negedge clk);
    reset_n = 1'b1; on = 1'b1; flash = 1'b0; ped_req = 1'b0;
    tick();
    repeat (30) cycle(1, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_2way.md
Name: traffic_ctrl_2way

Overview:
- Parametrised two-direction (north-south / east-west) intersection controller.
- Per-phase durations are set by parameters, with an all-red clearance phase between directions.
- Pedestrian requests are latched and served by extending a clearance phase with a WALK indication.
- A flashing-yellow maintenance mode is included. The block sits beside the single-lamp controller and drives both lamp heads plus a walk signal.

Parameters:
- TIMER_W, 8, phase timer width in bits.
- GREEN_T, 8, cycles per green phase (1..2^TIMER_W-1).
- YELLOW_T, 3, cycles per yellow phase (1..2^TIMER_W-1).
- CLR_T, 2, cycles per normal all-red clearance phase (1..2^TIMER_W-1).
- PED_T, 6, cycles per clearance phase that serves a pedestrian request (1..2^TIMER_W-1).
- FLASH_HALF_T, 4, half-period of the flashing yellow, in cycles (1..2^TIMER_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- on  in  1  enable; 0 forces OFF.
- flash  in  1  maintenance flashing-yellow mode request.
- ped_req  in  1  pedestrian request, 1-cycle pulse or level.
- ns_red, ns_yellow, ns_green  out  1 each  north-south lamps.
- ew_red, ew_yellow, ew_green  out  1 each  east-west lamps.
- walk  out  1  pedestrian WALK indication.
- ped_pend  out  1  a pedestrian request is latched and not yet served.
- state_out  out  3  current state encoding.

Behaviour:
- State encoding (state_out): OFF=0, AR_TO_NS=1, NS_GREEN=2, NS_YELLOW=3, AR_TO_EW=4, EW_GREEN=5, EW_YELLOW=6, FLASH=7.
- Reset (async, reset_n=0): state=OFF, timer=0, ped_pend=0, flash phase=lit, and every output is 0.
- Lamp outputs and walk are decoded combinationally from registered state only; there are no input-to-output combinational paths.
- Lamp decode per state:
  - OFF: all lamps 0.
  - AR_*: ns_red=ew_red=1.
  - NS_GREEN: ns_green=1, ew_red=1.
  - NS_YELLOW: ns_yellow=1, ew_red=1.
  - EW_GREEN and EW_YELLOW: mirror of the NS states.
  - FLASH: ns_yellow=ew_yellow=flash phase; all other lamps 0.
- Transition priority, evaluated each edge:
  - on=0: next state is OFF, timer cleared, ped_pend cleared.
  - Otherwise flash=1: next state is FLASH (from any state); timer cleared on entry; flash phase=lit on entry.
  - Otherwise the normal sequence below applies.
- Normal sequence: OFF→AR_TO_NS (first edge with on=1), then AR_TO_NS→NS_GREEN→NS_YELLOW→AR_TO_EW→EW_GREEN→EW_YELLOW→AR_TO_NS.
- FLASH with flash=0 (and on=1) goes to AR_TO_NS at the next edge with timer cleared.
- Phase timing:
  - Timer is 0 on state entry and increments each cycle.
  - The state exits at the edge where timer==dur-1, and the timer clears at that same edge. Each state therefore occupies exactly dur cycles.
  - dur is GREEN_T, YELLOW_T, or CLR_T; an AR state with walk active uses PED_T.
- Flash timing: the timer counts 0..FLASH_HALF_T-1; at FLASH_HALF_T-1 the flash phase toggles and the timer clears.
- Pedestrian handling:
  - ped_pend is set by ped_req=1 on any edge where on=1 and flash=0.
  - At the edge entering an AR state, walk_active is set to the current ped_pend and ped_pend is cleared. If ped_req is high on that same edge, set wins: ped_pend stays 1 and is carried to the next AR state.
  - walk=walk_active while in an AR state; walk=0 in all other states.
  - ped_req is ignored while on=0 or flash=1; ped_pend is held, not cleared, during FLASH.
- Arithmetic: the timer never exceeds dur-1, so no wrap-around occurs. Parameters outside the legal ranges are a configuration error, detected by an elaboration check.

Decomposition:
- Package traffic_pkg holds:
  - the state encoding constants (3-bit);
  - the lamp decode function state→{ns,ew}{r,y,g}.
- Sub-module phase_timer (TIMER_W):
  - inputs: clear, dur;
  - outputs: done (timer==dur-1) and count.
  - Instantiated once; the FSM selects dur.

Test Plan:
- Reset, then on=1 with defaults → state_out 1(2 cycles), 2(8), 3(3), 4(2), 5(8), 6(3), then 1 again; full loop is 26 cycles. The two red lamps are never both off while out of OFF/FLASH.
- Pulse ped_req during NS_GREEN → ped_pend=1; AR_TO_EW lasts 6 cycles with walk=1 and ped_pend=0; the following AR_TO_NS lasts 2 cycles with walk=0; loop is 30 cycles.
- flash=1 during EW_GREEN → next edge state 7; yellows alternate 4 on / 4 off with reds and greens 0; ped_req is ignored. Drop flash → AR_TO_NS with full 2-cycle clearance.
- on=0 at cycle 3 of NS_GREEN → next edge state 0, all lamps 0, ped_pend 0. Reassert on → AR_TO_NS, then NS_GREEN for a full 8 cycles.
- ped_pend=1 and ped_req=1 on the edge entering AR_TO_NS → walk=1 for 6 cycles; ped_pend stays 1; the next AR_TO_EW also gives walk=1.
- Assert reset_n=0 mid-AR with walk=1, between clock edges → all outputs 0 immediately, state_out=0. Release and set on=1 → restart at AR_TO_NS.
